// File: rtl/regfile_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | regfile_arbiter: round-robin two-requester sequencer for a 4x8 regfile.  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module regfile_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              gnt0,
  output logic              ack0,
  output logic              err0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt1,
  output logic              ack1,
  output logic              err1,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] rf_addr,
  output logic              rf_rw,
  output logic [DATA_W-1:0] rf_wdata,
  input  logic [DATA_W-1:0] rf_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t r_state;
  logic   r_last;
  logic   r_idx;
  logic   r_we;
  logic   r_oor;
  logic   w_win;
  logic   w_oor;

  // On a tie the requester not served last wins; otherwise the sole requester.
  assign w_win = (req0 && req1) ? ~r_last : req1;
  // rf_addr doubles as the latched request address.
  assign w_oor = (rf_addr >= ADDR_W'(DEPTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_last   <= 1'b1;
      r_idx    <= 1'b0;
      r_we     <= 1'b0;
      r_oor    <= 1'b0;
      gnt0     <= 1'b0;
      gnt1     <= 1'b0;
      ack0     <= 1'b0;
      ack1     <= 1'b0;
      err0     <= 1'b0;
      err1     <= 1'b0;
      rdata0   <= '0;
      rdata1   <= '0;
      rf_addr  <= '0;
      rf_rw    <= 1'b0;
      rf_wdata <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req0 || req1) begin
            r_idx    <= w_win;
            r_we     <= w_win ? we1 : we0;
            rf_addr  <= w_win ? addr1 : addr0;
            rf_wdata <= w_win ? wdata1 : wdata0;
            gnt0     <= ~w_win;
            gnt1     <= w_win;
            r_state  <= SETUP;
          end
        end
        SETUP: begin
          // rw rises only after addr/wdata have been stable for a full cycle.
          r_oor   <= w_oor;
          rf_rw   <= r_we && !w_oor;
          r_state <= ACCESS;
        end
        ACCESS: begin
          rf_rw <= 1'b0;
          if (r_oor || !r_we) begin
            if (r_idx) rdata1 <= r_oor ? '0 : rf_rdata;
            else       rdata0 <= r_oor ? '0 : rf_rdata;
          end
          ack0    <= ~r_idx;
          ack1    <= r_idx;
          err0    <= ~r_idx && r_oor;
          err1    <= r_idx && r_oor;
          r_state <= DONE;
        end
        DONE: begin
          ack0    <= 1'b0;
          ack1    <= 1'b0;
          err0    <= 1'b0;
          err1    <= 1'b0;
          gnt0    <= 1'b0;
          gnt1    <= 1'b0;
          r_last  <= r_idx;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/regfile_arbiter.md
# regfile_arbiter

Two-port arbiter and sequencer in front of the single-port 4 x 8-bit register file. It accepts independent read/write requests from two requesters, grants one at a time round-robin, and drives the register file's addr/rw/wdata in a safe setup–access–release sequence so that rw never rises while addr or wdata are changing. Read data is registered per requester, and out-of-range addresses are rejected without touching the register file.

## Interface

- ADDR_W, 5, address width of requester and register-file ports
- DATA_W, 8, data width
- DEPTH, 4, number of implemented registers; addresses >= DEPTH are out of range
- clk  input  1  clock, all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- reqN (N=0,1)  input  1  request, level; held until ackN
- weN  input  1  1 = write, 0 = read; stable while reqN high
- addrN  input  ADDR_W  target address; stable while reqN high
- wdataN  input  DATA_W  write data; stable while reqN high
- gntN  output  1  requester N owns the register file (SETUP through DONE)
- ackN  output  1  one-cycle completion pulse
- errN  output  1  valid with ackN; 1 = out-of-range address
- rdataN  output  DATA_W  registered read data for requester N
- rf_addr  output  ADDR_W  to register file addr
- rf_rw  output  1  to register file rw (1 = write)
- rf_wdata  output  DATA_W  to register file wdata
- rf_rdata  input  DATA_W  from register file out

## Operation

- FSM states: IDLE, SETUP, ACCESS, DONE.
- IDLE: if any reqN is high, choose a winner, latch its we/addr/wdata and its index into internal registers, and go to SETUP. Otherwise stay in IDLE.
- Round-robin: a sole requester wins. When both request, the one not granted last wins. last_grant resets to 1, so requester 0 wins the first tie.
- SETUP: rf_addr and rf_wdata are driven from the latched values; rf_rw=0. The range check (addr >= DEPTH) is evaluated here. Go to ACCESS.
- ACCESS:
  - In-range write: rf_rw=1 for exactly this cycle.
  - In-range read: rf_rw=0, and rf_rdata is captured into rdata of the granted requester at the end of this cycle.
  - Out-of-range: rf_rw=0, and the granted rdata is loaded with 0.
  - Go to DONE.
- DONE: rf_rw=0, with rf_addr and rf_wdata held. ackN=1 for the granted requester, and errN=1 if out-of-range. last_grant is updated. Go to IDLE.
- gntN is high from SETUP through DONE for the granted requester only.
- rdataN changes only on a completed read (or rejected read/write) by requester N; otherwise it holds.
- Writes never modify rdataN except on out-of-range, which loads 0.
- rf_addr and rf_wdata change only on the IDLE->SETUP transition.

## Timing

- Reset (asynchronous, immediate) values:
  - All outputs: ack0/1=0, err0/1=0, gnt0/1=0, rdata0/1=0, rf_rw=0, rf_addr=0, rf_wdata=0.
  - Internal: state=IDLE, last_grant=1.
- Latency: if req is sampled high in IDLE at edge E, then SETUP follows E, ACCESS follows E+1, and ack is high in the cycle after E+2. That is 3 cycles from sampling to ack.
- Throughput: one transaction per 4 cycles.
- Handshake:
  - The requester deasserts reqN on the edge where it sees ackN=1.
  - A reqN still high in the IDLE cycle after DONE is a new request.
  - Requests that arrive during SETUP, ACCESS or DONE wait; they are not dropped.
- Simultaneous requests in IDLE are resolved by last_grant only.
- A loser's request is served immediately after the winner's DONE, giving a 4-cycle ack spacing.
- Reset during ACCESS forces rf_rw to 0 asynchronously; the in-flight transaction is abandoned with no ack and rdata cleared.
- Requester inputs are ignored outside IDLE; changes during a transaction do not affect it.

## Test plan

- Reset with register file contents {2,5,0,3}; req0 read addr 1 -> gnt0 in SETUP..DONE, rf_rw stays 0, ack0 3 cycles after sampling, rdata0=5, err0=0.
- req1 write addr 2 data 0xA5, then req1 read addr 2 -> exactly one cycle with rf_rw=1, rf_addr=2 and rf_wdata=0xA5 stable the cycle before and after; read returns rdata1=0xA5.
- req0 and req1 both raised in the same cycle after reset, both held -> requester 0 completes first, then requester 1 with ack pulses 4 cycles apart; with both held continuously, grants alternate 0,1,0,1.
- req0 read addr 7 -> rf_rw never 1, ack0=1 with err0=1, rdata0=0; a following in-range read gives err0=0.
- rst_n asserted low in the ACCESS cycle of a write -> rf_rw drops to 0 immediately, no ack, all outputs at reset values, FSM in IDLE; after release the first request completes normally.
- req0 read addr 3 while addr0 is toggled to 0 during SETUP -> rdata0=3 (the latched address is used).
